// File: rtl/project_soc_key_pkg.sv
// Shared constants and types for the push-button controller:
// Avalon word offsets and the per-key debounce state.
package project_soc_key_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } db_state_e;

endpackage

// File: rtl/project_soc_key_debounce.sv
// One key: two-flop synchroniser, settle counter and accept FSM.
// Produces the debounced level and a one-cycle pulse on each press (1 -> 0).
module project_soc_key_debounce
    import project_soc_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic debounced,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    db_state_e        state;
    db_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             deb_nxt;
    logic             deb_prev;

    // Sync flops reset to 1 so idle (released) pins never look like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0   <= 1'b1;
            sync_p1   <= 1'b1;
            state     <= ST_STABLE;
            cnt       <= '0;
            debounced <= 1'b1;
            deb_prev  <= 1'b1;
        end else begin
            sync_p0   <= pin;
            sync_p1   <= sync_p0;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            debounced <= deb_nxt;
            deb_prev  <= debounced;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        deb_nxt   = debounced;
        case (state)
            ST_STABLE: begin
                if (sync_p1 != debounced) begin
                    state_nxt = ST_SETTLING;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            ST_SETTLING: begin
                if (sync_p1 == debounced) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    deb_nxt   = sync_p1;
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign fall = deb_prev & ~debounced;

endmodule

// File: rtl/project_soc_key_ctrl.sv
// Avalon-MM push-button controller: debounced data, interrupt mask and
// sticky press capture, with a registered level interrupt.
module project_soc_key_ctrl
    import project_soc_key_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_nxt;
    logic [31:0]      rd_nxt;
    logic             wr_en;
    logic             wd_unused;

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        project_soc_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .pin      (in_port[i]),
            .debounced(debounced[i]),
            .fall     (fall[i])
        );
    end

    assign wr_en     = chipselect & ~write_n;
    assign wd_unused = ^writedata[31:WIDTH];

    // Press is OR-ed in after the clear so a coincident press is never lost.
    always_comb begin
        edge_nxt = edge_capture;
        if (wr_en && address == ADDR_EDGE)
            edge_nxt = edge_nxt & ~writedata[WIDTH-1:0];
        edge_nxt = edge_nxt | fall;
    end

    always_comb begin
        rd_nxt = '0;
        case (address)
            ADDR_DATA: rd_nxt = 32'(debounced);
            ADDR_MASK: rd_nxt = 32'(irq_mask);
            ADDR_EDGE: rd_nxt = 32'(edge_capture);
            default:   rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            irq          <= 1'b0;
            readdata     <= '0;
        end else begin
            if (wr_en && address == ADDR_MASK)
                irq_mask <= writedata[WIDTH-1:0];
            edge_capture <= edge_nxt;
            irq          <= |(edge_capture & irq_mask);
            readdata     <= rd_nxt;
        end
    end

endmodule

// File: tb/tb_project_soc_key_ctrl.sv
// Self-checking bench for project_soc_key_ctrl: directed scenarios with literal
// expectations plus randomized pins/bus traffic against a run-length model.
module tb_project_soc_key_ctrl;

    localparam int WIDTH = 2;
    localparam int DC    = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address = 2'd0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port = '1;
    logic             irq;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    project_soc_key_ctrl #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    // Reference model: a key is accepted once its synchronised level has
    // disagreed with the accepted level for DC consecutive cycles.
    logic [WIDTH-1:0] m_d1, m_d2, m_deb, m_fell, m_mask, m_edge, m_new;
    int               m_run [WIDTH];
    logic [31:0]      m_rd;
    logic             m_irq;
    logic             m_wr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_d1 = '1; m_d2 = '1; m_deb = '1; m_fell = '0;
            m_mask = '0; m_edge = '0; m_rd = '0; m_irq = 1'b0;
            for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
        end else begin
            m_wr = chipselect && !write_n;
            case (address)
                2'd0:    m_rd = 32'(m_deb);
                2'd2:    m_rd = 32'(m_mask);
                2'd3:    m_rd = 32'(m_edge);
                default: m_rd = '0;
            endcase
            m_irq = |(m_edge & m_mask);
            if (m_wr && address == 2'd2) m_mask = writedata[WIDTH-1:0];
            if (m_wr && address == 2'd3) m_edge = m_edge & ~writedata[WIDTH-1:0];
            m_edge = m_edge | m_fell;
            m_new = m_deb;
            for (int i = 0; i < WIDTH; i++) begin
                if (m_d2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_new[i] = m_d2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_fell = m_deb & ~m_new;
            m_deb  = m_new;
            m_d2   = m_d1;
            m_d1   = in_port;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (readdata !== m_rd) begin
                errors++;
                $display("FAIL model_readdata t=%0t actual=%h required=%h", $time, readdata, m_rd);
            end
            checks++;
            if (irq !== m_irq) begin
                errors++;
                $display("FAIL model_irq t=%0t actual=%b required=%b", $time, irq, m_irq);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        write_n = 1'b1; chipselect = 1'b0;
    endtask

    logic [31:0] d;
    int          lat;
    logic        irq_before;
    int          hold [WIDTH];

    initial begin
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1 cmp_en = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Reset state.
        rd(2'd0, d); chk("reset_data", d, 32'h3);
        rd(2'd2, d); chk("reset_mask", d, 32'h0);
        rd(2'd3, d); chk("reset_edge", d, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);

        // Short glitch is rejected.
        in_port[0] = 1'b0; tick(10);
        in_port[0] = 1'b1; tick(25);
        rd(2'd0, d); chk("glitch_data", d, 32'h3);
        rd(2'd3, d); chk("glitch_edge", d, 32'h0);

        // Held press: accept latency from the sampling edge.
        address = 2'd0;
        in_port[0] = 1'b0;
        @(negedge clk);
        lat = 0;
        while (readdata != 32'h2 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("press_latency", 32'(lat), 32'd18);
        rd(2'd3, d); chk("press_edge", d, 32'h1);
        chk("press_irq_masked", 32'(irq), 32'h0);
        in_port[0] = 1'b1; tick(25);

        // Masked interrupt follows capture by one cycle, clear drops it.
        wr(2'd2, 32'hFFFF_FFFD);
        rd(2'd2, d); chk("mask_read", d, 32'h1);
        chk("irq_pending_old", 32'(irq), 32'h1);
        wr(2'd3, 32'h1); tick(1);
        chk("irq_cleared", 32'(irq), 32'h0);
        address = 2'd3;
        in_port[0] = 1'b0;
        irq_before = 1'b0;
        lat = 0;
        while (readdata[0] != 1'b1 && lat < 40) begin
            irq_before = irq;
            @(negedge clk);
            lat++;
        end
        chk("irq_before_capture", 32'(irq_before), 32'h0);
        chk("irq_with_capture", 32'(irq), 32'h1);
        in_port[0] = 1'b1; tick(25);
        wr(2'd3, 32'h1);
        chk("irq_clear_lag", 32'(irq), 32'h1);
        tick(1);
        chk("irq_after_clear", 32'(irq), 32'h0);
        rd(2'd3, d); chk("edge_after_clear", d, 32'h0);

        // Clear of bit 1 lands on the same edge that captures key 1's press.
        in_port[1] = 1'b0;
        tick(18);
        wr(2'd3, 32'h2);
        rd(2'd3, d); chk("set_wins", d, 32'h2);
        wr(2'd3, 32'h3);
        in_port[1] = 1'b1; tick(25);
        rd(2'd3, d); chk("edge_cleared_again", d, 32'h0);

        // Reset in the middle of settling.
        in_port[0] = 1'b0;
        tick(10);
        chk("settle_cnt", 32'(dut.g_key[0].u_db.cnt), 32'd8);
        #2 reset_n = 1'b0;
        in_port = '1;
        #1 chk("reset_cnt", 32'(dut.g_key[0].u_db.cnt), 32'd0);
        chk("reset_irq_async", 32'(irq), 32'h0);
        tick(3);
        reset_n = 1'b1;
        tick(2);
        rd(2'd0, d); chk("rst_data", d, 32'h3);
        rd(2'd2, d); chk("rst_mask", d, 32'h0);
        rd(2'd3, d); chk("rst_edge", d, 32'h0);
        tick(30);
        rd(2'd3, d); chk("rst_no_edge", d, 32'h0);

        // Randomized pins and bus traffic.
        for (int i = 0; i < WIDTH; i++) hold[i] = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (hold[i] == 0) begin
                    in_port[i] = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14))
                                                          : int'($urandom_range(17, 45));
                end else begin
                    hold[i]--;
                end
            end
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 5) != 0);
            writedata  = $urandom;
            @(negedge clk);
        end
        chipselect = 1'b0; write_n = 1'b1;
        tick(2);
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
